// File: rtl/fetch_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : fetch_pipe_ctrl
// Description: PC and IF/ID register owner for the WISC-SP13 fetch stage;
//              sequences imem reads, applies stalls, redirects and HALT.
// Revision   : 1.0 - initial release
// ============================================================================
module fetch_pipe_ctrl #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWrite,
   input  logic        IFWrite,
   input  logic        EnableNop,
   input  logic        BranchTaken,
   input  logic [15:0] BranchTarget,
   input  logic        Halt,
   input  logic [15:0] IMemInstr,
   input  logic        IMemDone,
   input  logic        IMemStall,
   output logic        IMemRd,
   output logic [15:0] PC,
   output logic [15:0] FDInstr,
   output logic [15:0] FDPCPlus2,
   output logic        FDValid,
   output logic        Halted
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        drop_q, drop_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] fd_instr_q, fd_instr_d;
   logic [15:0] fd_pc2_q, fd_pc2_d;
   logic        fd_valid_q, fd_valid_d;
   logic        halted_q, halted_d;
   logic [15:0] w_pc_plus2;
   logic        w_unused_stall;

   // Completion is signalled by IMemDone alone; Stall carries no extra information.
   assign w_unused_stall = IMemStall;
   assign w_pc_plus2     = pc_q + 16'd2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_FETCH;
         drop_q     <= 1'b0;
         pc_q       <= RESET_PC;
         fd_instr_q <= NOP_INSTR;
         fd_pc2_q   <= 16'h0000;
         fd_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         drop_q     <= drop_d;
         pc_q       <= pc_d;
         fd_instr_q <= fd_instr_d;
         fd_pc2_q   <= fd_pc2_d;
         fd_valid_q <= fd_valid_d;
         halted_q   <= halted_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      drop_d     = drop_q;
      pc_d       = pc_q;
      fd_instr_d = fd_instr_q;
      fd_pc2_d   = fd_pc2_q;
      fd_valid_d = fd_valid_q;
      halted_d   = halted_q;

      if (state_q == S_HALT) begin
         // Frozen until reset.
      end else if (BranchTaken) begin
         pc_d       = BranchTarget;
         fd_instr_d = NOP_INSTR;
         fd_valid_d = 1'b0;
         // A read still in flight belongs to the old path and must be swallowed.
         if ((state_q == S_WAIT) && !IMemDone) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
         end else begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
         end
      end else if (Halt && fd_valid_q && !EnableNop) begin
         state_d    = S_HALT;
         halted_d   = 1'b1;
         drop_d     = 1'b0;
         fd_instr_d = NOP_INSTR;
         fd_valid_d = 1'b0;
      end else if (drop_q) begin
         if (IMemDone) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
         end
      end else if (IMemDone) begin
         state_d = S_FETCH;
         if (PCWrite && IFWrite) begin
            pc_d       = w_pc_plus2;
            fd_instr_d = IMemInstr;
            fd_pc2_d   = w_pc_plus2;
            fd_valid_d = 1'b1;
         end else if (IFWrite) begin
            fd_instr_d = NOP_INSTR;
            fd_valid_d = 1'b0;
         end
      end else begin
         state_d = S_WAIT;
         if (IFWrite) begin
            fd_instr_d = NOP_INSTR;
            fd_valid_d = 1'b0;
         end
      end
   end

   assign IMemRd    = (state_q != S_HALT);
   assign PC        = pc_q;
   assign FDInstr   = fd_instr_q;
   assign FDPCPlus2 = fd_pc2_q;
   assign FDValid   = fd_valid_q;
   assign Halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_fetch_pipe_ctrl
// Description: Directed and randomized self-checking bench for fetch_pipe_ctrl.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fetch_pipe_ctrl;

   localparam logic [15:0] C_NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst, PCWrite, IFWrite, EnableNop, BranchTaken, Halt;
   logic [15:0] BranchTarget, IMemInstr;
   logic        IMemDone, IMemStall;
   logic        IMemRd, FDValid, Halted;
   logic [15:0] PC, FDInstr, FDPCPlus2;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state, derived from the fetch rules rather than a state machine.
   logic [15:0] m_pc, m_instr, m_pc2;
   logic        m_valid, m_halted, m_busy, m_drop;

   fetch_pipe_ctrl dut (
      .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFWrite(IFWrite),
      .EnableNop(EnableNop), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Halt(Halt), .IMemInstr(IMemInstr), .IMemDone(IMemDone), .IMemStall(IMemStall),
      .IMemRd(IMemRd), .PC(PC), .FDInstr(FDInstr), .FDPCPlus2(FDPCPlus2),
      .FDValid(FDValid), .Halted(Halted)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      if (!rst) begin
         m_pc = 16'h0000; m_instr = C_NOP; m_pc2 = 16'h0000;
         m_valid = 1'b0; m_halted = 1'b0; m_busy = 1'b0; m_drop = 1'b0;
      end else if (m_halted) begin
         m_busy = 1'b0;
      end else if (BranchTaken) begin
         m_pc = BranchTarget; m_instr = C_NOP; m_valid = 1'b0;
         m_drop = m_busy && !IMemDone;
         m_busy = m_drop;
      end else if (Halt && m_valid && !EnableNop) begin
         m_halted = 1'b1; m_instr = C_NOP; m_valid = 1'b0;
      end else if (m_drop) begin
         if (IMemDone) begin m_drop = 1'b0; m_busy = 1'b0; end
      end else if (IMemDone) begin
         m_busy = 1'b0;
         if (PCWrite && IFWrite) begin
            m_instr = IMemInstr; m_pc2 = m_pc + 16'd2; m_pc = m_pc + 16'd2; m_valid = 1'b1;
         end else if (IFWrite) begin
            m_instr = C_NOP; m_valid = 1'b0;
         end
      end else begin
         m_busy = 1'b1;
         if (IFWrite) begin m_instr = C_NOP; m_valid = 1'b0; end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_idle();
      rst = 1'b1; PCWrite = 1'b1; IFWrite = 1'b1; EnableNop = 1'b0;
      BranchTaken = 1'b0; BranchTarget = 16'h0000; Halt = 1'b0;
      IMemDone = 1'b1; IMemStall = 1'b0; IMemInstr = 16'h0000;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_tests++; if (PC !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", PC); end
      n_tests++; if (FDInstr !== C_NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", FDInstr, C_NOP); end
      n_tests++; if (FDPCPlus2 !== 16'h0000) begin n_fail++; $display("FAIL reset_pc2 got=%h exp=0000", FDPCPlus2); end
      n_tests++; if (FDValid !== 1'b0 || Halted !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", FDValid, Halted); end
      n_tests++; if (IMemRd !== 1'b1) begin n_fail++; $display("FAIL reset_rd got=%b exp=1", IMemRd); end
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 2; k++) begin
         IMemDone = 1'b1; IMemInstr = 16'hA000 + 16'(k);
         tick();
         n_tests++; if (PC !== 16'(2 * (k + 1))) begin n_fail++; $display("FAIL seq_pc k=%0d got=%h exp=%h", k, PC, 16'(2 * (k + 1))); end
         n_tests++; if (FDInstr !== 16'hA000 + 16'(k) || FDValid !== 1'b1) begin n_fail++; $display("FAIL seq_instr k=%0d got=%h/%b exp=%h/1", k, FDInstr, FDValid, 16'hA000 + 16'(k)); end
         n_tests++; if (FDPCPlus2 !== 16'(2 * (k + 1))) begin n_fail++; $display("FAIL seq_pc2 k=%0d got=%h exp=%h", k, FDPCPlus2, 16'(2 * (k + 1))); end
      end
   endtask

   task automatic test_stall();
      PCWrite = 1'b0; IFWrite = 1'b0; IMemDone = 1'b1; IMemInstr = 16'hDEAD;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_tests++; if (PC !== 16'h0004) begin n_fail++; $display("FAIL stall_pc k=%0d got=%h exp=0004", k, PC); end
         n_tests++; if (FDInstr !== 16'hA001 || FDValid !== 1'b1) begin n_fail++; $display("FAIL stall_hold k=%0d got=%h/%b exp=a001/1", k, FDInstr, FDValid); end
      end
      PCWrite = 1'b1; IFWrite = 1'b1; IMemInstr = 16'hA002;
      tick();
      n_tests++; if (PC !== 16'h0006 || FDInstr !== 16'hA002 || FDPCPlus2 !== 16'h0006) begin
         n_fail++; $display("FAIL stall_release got=%h/%h/%h exp=0006/a002/0006", PC, FDInstr, FDPCPlus2); end
   endtask

   task automatic test_wait();
      IMemDone = 1'b0; IMemStall = 1'b1; IMemInstr = 16'hFFFF;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_tests++; if (FDValid !== 1'b0 || FDInstr !== C_NOP) begin n_fail++; $display("FAIL wait_bubble k=%0d got=%h/%b exp=0800/0", k, FDInstr, FDValid); end
         n_tests++; if (PC !== 16'h0006 || IMemRd !== 1'b1) begin n_fail++; $display("FAIL wait_pc k=%0d got=%h/%b exp=0006/1", k, PC, IMemRd); end
      end
      IMemDone = 1'b1; IMemStall = 1'b0; IMemInstr = 16'h1234;
      tick();
      n_tests++; if (FDInstr !== 16'h1234 || FDValid !== 1'b1 || FDPCPlus2 !== 16'h0008 || PC !== 16'h0008) begin
         n_fail++; $display("FAIL wait_done got=%h/%b/%h/%h exp=1234/1/0008/0008", FDInstr, FDValid, FDPCPlus2, PC); end
   endtask

   task automatic test_branch_in_wait();
      IMemDone = 1'b0; IMemStall = 1'b1;
      tick();
      BranchTaken = 1'b1; BranchTarget = 16'h0040;
      tick();
      BranchTaken = 1'b0;
      n_tests++; if (PC !== 16'h0040 || FDValid !== 1'b0) begin n_fail++; $display("FAIL bw_redirect got=%h/%b exp=0040/0", PC, FDValid); end
      tick();
      IMemDone = 1'b1; IMemStall = 1'b0; IMemInstr = 16'hBEEF;
      tick();
      n_tests++; if (FDInstr === 16'hBEEF || FDValid !== 1'b0 || PC !== 16'h0040) begin
         n_fail++; $display("FAIL bw_drop got=%h/%b/%h exp=0800/0/0040", FDInstr, FDValid, PC); end
      IMemInstr = 16'h5555;
      tick();
      n_tests++; if (FDInstr !== 16'h5555 || FDPCPlus2 !== 16'h0042 || PC !== 16'h0042) begin
         n_fail++; $display("FAIL bw_refetch got=%h/%h/%h exp=5555/0042/0042", FDInstr, FDPCPlus2, PC); end
   endtask

   task automatic test_branch_over_halt();
      BranchTaken = 1'b1; BranchTarget = 16'h0100; Halt = 1'b1; PCWrite = 1'b0;
      tick();
      set_idle();
      n_tests++; if (PC !== 16'h0100 || FDValid !== 1'b0 || Halted !== 1'b0) begin
         n_fail++; $display("FAIL br_halt got=%h/%b/%b exp=0100/0/0", PC, FDValid, Halted); end
   endtask

   task automatic test_halt();
      BranchTaken = 1'b1; BranchTarget = 16'h000E;
      tick();
      BranchTaken = 1'b0; IMemInstr = 16'h0000;
      tick();
      Halt = 1'b1;
      tick();
      Halt = 1'b0;
      n_tests++; if (Halted !== 1'b1 || IMemRd !== 1'b0 || PC !== 16'h0010 || FDValid !== 1'b0) begin
         n_fail++; $display("FAIL halt_enter got=%b/%b/%h/%b exp=1/0/0010/0", Halted, IMemRd, PC, FDValid); end
      for (int k = 0; k < 10; k++) begin
         BranchTaken = 1'($urandom_range(0, 1)); BranchTarget = 16'h0200;
         IMemDone = 1'($urandom_range(0, 1)); IMemInstr = 16'($urandom);
         tick();
         n_tests++; if (PC !== 16'h0010 || Halted !== 1'b1 || IMemRd !== 1'b0) begin
            n_fail++; $display("FAIL halt_hold k=%0d got=%h/%b/%b exp=0010/1/0", k, PC, Halted, IMemRd); end
      end
      set_idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_tests++; if (PC !== 16'h0000 || Halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset got=%h/%b exp=0000/0", PC, Halted); end
      IMemInstr = 16'h7777;
      tick();
      n_tests++; if (PC !== 16'h0002 || FDInstr !== 16'h7777 || FDValid !== 1'b1) begin
         n_fail++; $display("FAIL halt_resume got=%h/%h/%b exp=0002/7777/1", PC, FDInstr, FDValid); end
   endtask

   task automatic test_wrap();
      BranchTaken = 1'b1; BranchTarget = 16'hFFFE;
      tick();
      BranchTaken = 1'b0; IMemInstr = 16'h4242;
      tick();
      n_tests++; if (PC !== 16'h0000 || FDPCPlus2 !== 16'h0000 || FDInstr !== 16'h4242) begin
         n_fail++; $display("FAIL wrap got=%h/%h/%h exp=0000/0000/4242", PC, FDPCPlus2, FDInstr); end
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 39) != 0);
         BranchTaken = ($urandom_range(0, 9) == 0); BranchTarget = 16'($urandom);
         Halt = ($urandom_range(0, 14) == 0); EnableNop = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 9);
         PCWrite = (r < 7) || (r == 9); IFWrite = (r < 7) || (r == 8);
         IMemDone = ($urandom_range(0, 9) < 6); IMemStall = !IMemDone; IMemInstr = 16'($urandom);
         tick();
         n_tests++; if (PC !== m_pc) begin n_fail++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, PC, m_pc); end
         n_tests++; if (FDInstr !== m_instr) begin n_fail++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, FDInstr, m_instr); end
         n_tests++; if (FDPCPlus2 !== m_pc2) begin n_fail++; $display("FAIL rnd_pc2 c=%0d got=%h exp=%h", c, FDPCPlus2, m_pc2); end
         n_tests++; if (FDValid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, FDValid, m_valid); end
         n_tests++; if (Halted !== m_halted) begin n_fail++; $display("FAIL rnd_halted c=%0d got=%b exp=%b", c, Halted, m_halted); end
         n_tests++; if (IMemRd !== !m_halted) begin n_fail++; $display("FAIL rnd_rd c=%0d got=%b exp=%b", c, IMemRd, !m_halted); end
      end
   endtask

   initial begin
      set_idle();
      rst = 1'b0;
      #2;
      test_reset();
      test_sequential();
      test_stall();
      test_wait();
      test_branch_in_wait();
      test_branch_over_halt();
      test_halt();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
